// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_ctrl_pkg : widths, access-size encodings and controller states
// Revision     : 1.0
// ============================================================================
package mem_ctrl_pkg;

   localparam int ADDR_LEN = 32;
   localparam int REG_LEN  = 32;
   localparam int BYTE_LEN = 8;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Encoding 2'b11 is treated as a word access alongside LEN_WORD.
   function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
      case (len)
         LEN_BYTE: return 3'd1;
         LEN_HALF: return 3'd2;
         LEN_WORD: return 3'd4;
         default:  return 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : byte-serial RAM arbiter for instruction fetch and load/store
// Revision : 1.0
// ============================================================================
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_LEN-1:0] if_addr,
   input  logic                if_cancel,
   output logic                if_done,
   output logic [REG_LEN-1:0]  if_inst,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [ADDR_LEN-1:0] mem_addr,
   input  logic [1:0]          mem_len,
   input  logic [REG_LEN-1:0]  mem_wdata,
   output logic                mem_done,
   output logic [REG_LEN-1:0]  mem_rdata,
   input  logic [BYTE_LEN-1:0] ram_din,
   output logic [BYTE_LEN-1:0] ram_dout,
   output logic [ADDR_LEN-1:0] ram_a,
   output logic                ram_wr,
   output logic                busy
);

   state_t              state;
   logic                owner_if;
   logic [2:0]          cnt;
   logic [2:0]          nbytes;
   logic [REG_LEN-1:0]  asm_word;
   logic [REG_LEN-1:0]  asm_next;
   logic                fetch_done;
   logic [2:0]          mem_nbytes;

   assign mem_nbytes = len_to_bytes(mem_len);
   assign busy       = (state != ST_IDLE);
   // A flush arriving together with the completion pulse still hides it.
   assign if_done    = fetch_done & ~if_cancel;

   // RAM data lags its address by one edge, so count value k+1 carries byte k.
   always_comb begin
      asm_next = asm_word;
      case (cnt)
         3'd1:    asm_next[7:0]   = ram_din;
         3'd2:    asm_next[15:8]  = ram_din;
         3'd3:    asm_next[23:16] = ram_din;
         3'd4:    asm_next[31:24] = ram_din;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         owner_if   <= 1'b0;
         cnt        <= '0;
         nbytes     <= '0;
         asm_word   <= '0;
         ram_a      <= '0;
         ram_dout   <= '0;
         ram_wr     <= 1'b0;
         fetch_done <= 1'b0;
         mem_done   <= 1'b0;
         if_inst    <= '0;
         mem_rdata  <= '0;
      end else begin
         fetch_done <= 1'b0;
         mem_done   <= 1'b0;
         case (state)
            ST_IDLE: begin
               ram_wr <= 1'b0;
               if (mem_req && !mem_done) begin
                  owner_if <= 1'b0;
                  cnt      <= '0;
                  nbytes   <= mem_nbytes;
                  ram_a    <= mem_addr;
                  if (mem_we) begin
                     state    <= ST_WRITE;
                     ram_wr   <= 1'b1;
                     ram_dout <= mem_wdata[BYTE_LEN-1:0];
                     asm_word <= mem_wdata >> BYTE_LEN;
                     mem_done <= (mem_nbytes == 3'd1);
                  end else begin
                     state    <= ST_READ;
                     asm_word <= '0;
                  end
               end else if (if_req && !fetch_done && !if_cancel) begin
                  state    <= ST_READ;
                  owner_if <= 1'b1;
                  cnt      <= '0;
                  nbytes   <= 3'd4;
                  ram_a    <= if_addr;
                  asm_word <= '0;
               end
            end
            ST_READ: begin
               if (owner_if && if_cancel) begin
                  state <= ST_IDLE;
               end else begin
                  cnt      <= cnt + 3'd1;
                  asm_word <= asm_next;
                  if (cnt + 3'd1 < nbytes)
                     ram_a <= ram_a + 1'b1;
                  if (cnt == nbytes) begin
                     state <= ST_IDLE;
                     if (owner_if) begin
                        if_inst    <= asm_next;
                        fetch_done <= 1'b1;
                     end else begin
                        mem_rdata <= asm_next;
                        mem_done  <= 1'b1;
                     end
                  end
               end
            end
            ST_WRITE: begin
               // The done pulse overlaps the last byte being driven.
               if (cnt + 3'd1 < nbytes) begin
                  cnt      <= cnt + 3'd1;
                  ram_a    <= ram_a + 1'b1;
                  ram_dout <= asm_word[BYTE_LEN-1:0];
                  asm_word <= asm_word >> BYTE_LEN;
                  mem_done <= (cnt + 3'd2 == nbytes);
               end else begin
                  state  <= ST_IDLE;
                  ram_wr <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               ram_wr <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on its rising edge.
REQ-002 rst  in  1  reset, synchronous and active-low: sampled only on a rising clk edge, asserted when 0.
REQ-003 if_req  in  1  instruction-fetch request; held high until if_done.
REQ-004 if_addr  in  32  fetch byte address; stable while if_req is high.
REQ-005 if_cancel  in  1  pipeline flush; aborts pending or in-flight fetch.
REQ-006 if_done  out  1  one-cycle pulse; fetch complete.
REQ-007 if_inst  out  32  fetched word; valid only while if_done=1.
REQ-008 mem_req  in  1  load/store request; held high until mem_done.
REQ-009 mem_we  in  1  1=store, 0=load; stable with mem_req.
REQ-010 mem_addr  in  32  data byte address.
REQ-011 mem_len  in  2  access size: 00=1 byte, 01=2 bytes, 10/11=4 bytes.
REQ-012 mem_wdata  in  32  store data; low-order bytes used.
REQ-013 mem_done  out  1  one-cycle pulse; load or store complete.
REQ-014 mem_rdata  out  32  load data, zero-extended, little-endian; valid only while mem_done=1.
REQ-015 ram_din  in  8  RAM read byte; returns data for the address RAM sampled one edge earlier.
REQ-016 ram_dout  out  8  RAM write byte.
REQ-017 ram_a  out  32  RAM byte address.
REQ-018 ram_wr  out  1  1=write ram_dout at ram_a on the next edge.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 States: IDLE, READ, WRITE; single owner (IF or MEM) latched on acceptance.
REQ-021 Accept only in IDLE; priority: mem_req over if_req; no preemption of an accepted transaction.
REQ-022 A requester whose done is high in the current cycle is not accepted in that cycle.
REQ-023 All ram_* outputs are registered; ram_wr=0 in IDLE and READ.
REQ-024 Read of N bytes accepted at edge E0: ram_a=addr+k during cycle k+1; byte k captured at edge E(k+2); done pulses in the cycle after E(N+1); returns to IDLE at E(N+1).
REQ-025 Read latency, from the request cycle to the done cycle: 1 byte = 3 cycles, 2 bytes = 4, 4 bytes = 6.
REQ-026 Write of N bytes: ram_a=addr+k, ram_dout=wdata[8k+7:8k], ram_wr=1 during cycle k+1, for k=0..N-1; mem_done pulses in cycle N; IDLE in cycle N+1.
REQ-027 Byte order little-endian: byte k maps to bits [8k+7:8k]; unread upper bytes return 0.
REQ-028 Address increment is modulo 2^32: 0xFFFFFFFF+1 = 0x00000000.
REQ-029 IF fetches are always 4-byte reads.
REQ-030 if_cancel=1 while the IF owns READ: the fetch is aborted, IDLE is entered next edge, if_done is never pulsed for it.
REQ-031 if_cancel=1 in IDLE: if_req is not accepted that cycle.
REQ-032 if_cancel has no effect on a MEM transaction.
REQ-033 Simultaneous if_cancel and if_done for the same fetch: if_done is suppressed.

Reset
REQ-034 On rst=0 at an edge: state=IDLE; ram_a=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0, busy=0.
REQ-035 Reset mid-transaction aborts it, with no done pulse; ram_wr is 0 in the first cycle after the reset edge.

Structure
REQ-036 A shared package holds the AddrLen/RegLen/ByteLen widths, the mem_len encodings and the state encoding.
REQ-037 Single module; no sub-module; one state register, one 3-bit byte counter, one 32-bit assembly register.

Verification
REQ-038 IF read: if_req, addr 0x100, RAM bytes 13,00,00,00 -> if_done in the 6th cycle, if_inst=0x00000013.
REQ-039 Simultaneous mem_req (1-byte load, addr 0x20, byte 0xFF) and if_req -> mem_done first with mem_rdata=0x000000FF; the IF read starts afterwards.
REQ-040 Store word 0xDEADBEEF at 0x40 -> ram_wr=1 for 4 cycles with bytes EF,BE,AD,DE at 0x40..0x43; mem_done in cycle 4.
REQ-041 if_cancel in the 3rd cycle of a fetch -> no if_done; busy=0 next cycle; a queued mem_req is accepted.
REQ-042 Half-word load at 0xFFFFFFFF -> addresses 0xFFFFFFFF then 0x00000000; mem_rdata assembles both bytes.
REQ-043 rst=0 during the 2nd byte of a word store -> ram_wr=0 next cycle; no mem_done; all outputs at reset values.
